// File: rtl/key_schedule_ctrl.sv
// key_schedule_ctrl: iterative AES-128 key schedule, one round key per clock into an 11-slot register file.
//   clk          in   clock, all state on rising edge
//   i_Reset      in   synchronous active-high reset
//   i_Zeroize    in   (KEY_SCHED_ZEROIZE_EN only) clear slots and W, abort to IDLE
//   i_Start      in   start request, sampled in IDLE
//   i_Key        in   128-bit cipher key, captured on the accepting edge
//   i_Rd_Addr    in   round-key read index 0..10
//   o_Rd_Key     out  combinational round-key read, 0 for index > 10
//   o_Busy       out  schedule generation in progress
//   o_Done       out  one-cycle pulse after round key 10 is written
//   o_Keys_Valid out  all slots hold the schedule of the last accepted key
// Optional macro: KEY_SCHED_ZEROIZE_EN adds the i_Zeroize port.

module key_sched_sbox (
   input  logic [7:0] i_In,
   output logic [7:0] o_Out
);
   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };
   assign o_Out = SBOX[i_In];
endmodule

module key_schedule_ctrl #(
   parameter int NUM_ROUNDS = 10,
   parameter int RD_ADDR_W  = 4
) (
   input  logic                 clk,
   input  logic                 i_Reset,
`ifdef KEY_SCHED_ZEROIZE_EN
   input  logic                 i_Zeroize,
`endif
   input  logic                 i_Start,
   input  logic [127:0]         i_Key,
   input  logic [RD_ADDR_W-1:0] i_Rd_Addr,
   output logic [127:0]         o_Rd_Key,
   output logic                 o_Busy,
   output logic                 o_Done,
   output logic                 o_Keys_Valid
);
   typedef enum logic {IDLE, RUN} state_t;
   localparam logic [3:0]           LAST     = 4'(NUM_ROUNDS);
   localparam logic [RD_ADDR_W-1:0] MAX_ADDR = RD_ADDR_W'(NUM_ROUNDS);
   state_t       state_q, state_d;
   logic [127:0] w_q, w_d;
   logic [3:0]   round_q, round_d;
   logic [7:0]   rcon_q, rcon_d;
   logic         done_q, done_d, valid_q, valid_d;
   logic [127:0] slots_q [0:10];
   logic [127:0] slots_d [0:10];
   logic         zeroize;
   logic [31:0]  rot, sub, temp, w4, w5, w6, w7;
   logic [127:0] next_w;
`ifdef KEY_SCHED_ZEROIZE_EN
   assign zeroize = i_Zeroize;
`else
   assign zeroize = 1'b0;
`endif
   // Shared SubWord path: the only S-box use in the block.
   assign rot = {w_q[23:0], w_q[31:24]};
   for (genvar g = 0; g < 4; g++) begin : g_sbox
      key_sched_sbox u_sbox (.i_In(rot[8*g +: 8]), .o_Out(sub[8*g +: 8]));
   end
   assign temp   = sub ^ {rcon_q, 24'h0};
   assign w4     = w_q[127:96] ^ temp;
   assign w5     = w_q[95:64] ^ w4;
   assign w6     = w_q[63:32] ^ w5;
   assign w7     = w_q[31:0] ^ w6;
   assign next_w = {w4, w5, w6, w7};
   always_ff @(posedge clk) begin
      if (i_Reset) begin
         state_q <= IDLE;
         w_q     <= '0;
         round_q <= '0;
         rcon_q  <= 8'h01;
         done_q  <= 1'b0;
         valid_q <= 1'b0;
         slots_q <= '{default: '0};
      end else begin
         state_q <= state_d;
         w_q     <= w_d;
         round_q <= round_d;
         rcon_q  <= rcon_d;
         done_q  <= done_d;
         valid_q <= valid_d;
         slots_q <= slots_d;
      end
   end
   always_comb begin
      state_d = state_q;
      if (zeroize)
         state_d = IDLE;
      else if (state_q == IDLE)
         state_d = i_Start ? RUN : IDLE;
      else
         state_d = (round_q == LAST) ? IDLE : RUN;
   end
   always_comb begin
      w_d     = w_q;
      round_d = round_q;
      rcon_d  = rcon_q;
      done_d  = 1'b0;
      valid_d = valid_q;
      slots_d = slots_q;
      if (zeroize) begin
         w_d     = '0;
         round_d = '0;
         rcon_d  = 8'h01;
         valid_d = 1'b0;
         slots_d = '{default: '0};
      end else if (state_q == IDLE && i_Start) begin
         w_d        = i_Key;
         slots_d[0] = i_Key;
         round_d    = 4'd1;
         rcon_d     = 8'h01;
         valid_d    = 1'b0;
      end else if (state_q == RUN) begin
         w_d              = next_w;
         slots_d[round_q] = next_w;
         // xtime: rcon doubles in GF(2^8), wrapping 80 -> 1b -> 36.
         rcon_d  = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
         round_d = (round_q == LAST) ? 4'd0 : round_q + 4'd1;
         done_d  = (round_q == LAST);
         valid_d = (round_q == LAST);
      end
   end
   always_comb begin
      o_Busy       = (state_q == RUN);
      o_Done       = done_q;
      o_Keys_Valid = valid_q;
      o_Rd_Key     = (i_Rd_Addr <= MAX_ADDR) ? slots_q[i_Rd_Addr] : '0;
   end
endmodule

// File: tb/tb_key_schedule_ctrl.sv
// tb_key_schedule_ctrl: randomized scoreboard bench for key_schedule_ctrl against a word-level AES-128 expansion model.
`timescale 1ns/1ps
module tb_key_schedule_ctrl;
   logic         clk = 1'b0;
   logic         i_Reset = 1'b1;
   logic         i_Start = 1'b0;
   logic [127:0] i_Key = '0;
   logic [3:0]   i_Rd_Addr = '0;
   logic [127:0] o_Rd_Key;
   logic         o_Busy, o_Done, o_Keys_Valid;
`ifdef KEY_SCHED_ZEROIZE_EN
   logic         i_Zeroize = 1'b0;
`endif
   key_schedule_ctrl dut (
      .clk(clk), .i_Reset(i_Reset),
`ifdef KEY_SCHED_ZEROIZE_EN
      .i_Zeroize(i_Zeroize),
`endif
      .i_Start(i_Start), .i_Key(i_Key), .i_Rd_Addr(i_Rd_Addr),
      .o_Rd_Key(o_Rd_Key), .o_Busy(o_Busy), .o_Done(o_Done), .o_Keys_Valid(o_Keys_Valid)
   );
   always #5 clk = ~clk;
   typedef struct packed {
      logic [10:0][127:0] k;
      logic [31:0]        acc;
   } exp_t;
   exp_t        q[$];
   int          checks = 0, errors = 0, cyc = 0;
   logic [7:0]  sb [256];
   localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] SEQ_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h expected=%h", nm, act, exp);
      end
   endtask
   function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p ^= a;
         a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
         b = b >> 1;
      end
      return p;
   endfunction
   // S-box from its definition: multiplicative inverse followed by the affine map.
   function automatic logic [7:0] sbox_calc(logic [7:0] x);
      logic [7:0] inv = 8'h01;
      logic [7:0] s;
      if (x == 8'h00) inv = 8'h00;
      else for (int i = 0; i < 254; i++) inv = gmul(inv, x);
      s = 8'h63 ^ inv;
      for (int n = 1; n < 5; n++) s ^= (inv << n) | (inv >> (8 - n));
      return s;
   endfunction
   function automatic logic [10:0][127:0] expand(logic [127:0] key);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rc = 8'h01;
      logic [10:0][127:0] k;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
            rc = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 11; r++) k[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      return k;
   endfunction
   // Monitor: every o_Done must match the oldest outstanding schedule; sweeps the read port inside the done cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (o_Done) begin
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL spurious_done got=done_pulse expected=none at cycle %0d", cyc);
            end else begin
               e = q.pop_front();
               chk("done_latency", 128'(cyc), 128'(e.acc + 10));
               chk("busy_at_done", 128'(o_Busy), 128'(0));
               chk("valid_at_done", 128'(o_Keys_Valid), 128'(1));
               for (int a = 0; a < 16; a++) begin
                  i_Rd_Addr = 4'(a);
                  #0.25;
                  chk($sformatf("slot%0d", a), o_Rd_Key, (a <= 10) ? e.k[a] : 128'h0);
               end
            end
         end
      end
   end
   task automatic chk_slot(string nm, int a, logic [127:0] exp);
      i_Rd_Addr = 4'(a);
      #1;
      chk(nm, o_Rd_Key, exp);
   endtask
   task automatic start_run(logic [127:0] key, bit push);
      i_Key = key;
      i_Start = 1'b1;
      @(negedge clk);
      i_Start = 1'b0;
      if (push) q.push_back({expand(key), 32'(cyc)});
      chk("busy_after_accept", 128'(o_Busy), 128'(1));
      chk("valid_after_accept", 128'(o_Keys_Valid), 128'(0));
   endtask
   task automatic wait_done();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!o_Done && n < 40);
      checks++;
      if (!o_Done) begin
         errors++;
         $display("FAIL done_timeout got=no_done expected=done within 40 cycles");
      end
   endtask
   task automatic check_cleared(string tag);
      chk({tag, "_busy"}, 128'(o_Busy), 128'(0));
      chk({tag, "_valid"}, 128'(o_Keys_Valid), 128'(0));
      chk({tag, "_done"}, 128'(o_Done), 128'(0));
      for (int a = 0; a < 11; a++) chk_slot($sformatf("%s_slot%0d", tag, a), a, 128'h0);
   endtask
   initial begin
      logic [127:0] k;
      for (int i = 0; i < 256; i++) sb[i] = sbox_calc(8'(i));
      repeat (2) @(negedge clk);
      i_Reset = 1'b0;
      check_cleared("reset");
      chk_slot("reset_slot15", 15, 128'h0);
      // FIPS-197 vector
      start_run(FIPS_KEY, 1'b1);
      wait_done();
      @(negedge clk);
      chk_slot("fips_slot0", 0, FIPS_KEY);
      chk_slot("fips_slot1", 1, 128'ha0fafe1788542cb123a339392a6c7605);
      chk_slot("fips_slot10", 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      chk_slot("fips_slot12", 12, 128'h0);
      // Start during RUN at E4 is ignored
      start_run(FIPS_KEY, 1'b1);
      repeat (3) @(negedge clk);
      i_Key = SEQ_KEY;
      i_Start = 1'b1;
      @(negedge clk);
      i_Start = 1'b0;
      chk("busy_mid_run", 128'(o_Busy), 128'(1));
      wait_done();
      repeat (3) @(negedge clk);
      // Reset at E5 aborts without o_Done
      start_run({$urandom, $urandom, $urandom, $urandom}, 1'b0);
      repeat (4) @(negedge clk);
      i_Reset = 1'b1;
      @(negedge clk);
      i_Reset = 1'b0;
      check_cleared("abort");
      repeat (15) @(negedge clk);
      start_run({$urandom, $urandom, $urandom, $urandom}, 1'b1);
      wait_done();
      // Back-to-back with i_Start held high, key changed in the done cycle
      i_Key = {$urandom, $urandom, $urandom, $urandom};
      i_Start = 1'b1;
      @(negedge clk);
      q.push_back({expand(i_Key), 32'(cyc)});
      wait_done();
      i_Key = SEQ_KEY;
      @(negedge clk);
      q.push_back({expand(SEQ_KEY), 32'(cyc)});
      i_Start = 1'b0;
      chk("b2b_busy", 128'(o_Busy), 128'(1));
      wait_done();
      @(negedge clk);
      chk_slot("b2b_slot10", 10, 128'h13111d7fe3944a17f307a78b4d2b30c5);
      // Random keys, random ignored starts, random gaps including zero
      for (int r = 0; r < 8; r++) begin
         start_run({$urandom, $urandom, $urandom, $urandom}, 1'b1);
         if ($urandom_range(1, 0) == 1) begin
            repeat ($urandom_range(8, 1)) @(negedge clk);
            i_Key = {$urandom, $urandom, $urandom, $urandom};
            i_Start = 1'b1;
            @(negedge clk);
            i_Start = 1'b0;
         end
         wait_done();
         repeat ($urandom_range(3, 0)) @(negedge clk);
      end
`ifdef KEY_SCHED_ZEROIZE_EN
      repeat (2) @(negedge clk);
      start_run({$urandom, $urandom, $urandom, $urandom}, 1'b0);
      repeat (2) @(negedge clk);
      i_Zeroize = 1'b1;
      i_Start = 1'b1;
      @(negedge clk);
      i_Zeroize = 1'b0;
      i_Start = 1'b0;
      check_cleared("zeroize");
      @(negedge clk);
      chk("zeroize_start_discarded", 128'(o_Busy), 128'(0));
      repeat (15) @(negedge clk);
`endif
      repeat (3) @(negedge clk);
      chk("scoreboard_empty", 128'(q.size()), 128'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/key_schedule_ctrl.md
Name: key_schedule_ctrl

Overview:
Iterative AES-128 key-schedule sequencer. It accepts a cipher key with a start handshake and generates one round key per clock through a single shared 4-byte SubWord path (4 sbox instances). The 11 round keys go into an internal register file, which a round datapath reads by round index. This is the area-reduced alternative to the fully unrolled 40-sbox expansion, and it feeds the iterative cipher core.

Parameters:
NUM_ROUNDS, 10, number of round keys generated after round 0; only 10 is supported (AES-128).
RD_ADDR_W, 4, width of the round-key read address.

Ports:
clk  input  1  clock; all state updates on rising edge
i_Reset  input  1  synchronous, active-high reset
i_Start  input  1  start request; sampled only in IDLE
i_Key  input  128  cipher key; sampled on the accepting edge only
i_Rd_Addr  input  RD_ADDR_W  round-key read index, 0..10
o_Rd_Key  output  128  round key at i_Rd_Addr (combinational read)
o_Busy  output  1  schedule generation in progress
o_Done  output  1  one-cycle pulse when round key 10 has been written
o_Keys_Valid  output  1  all 11 slots hold the schedule of the last accepted key

Behaviour:
- Reset (synchronous, active-high; clk and i_Reset as named above).
  - Sets state to IDLE; o_Busy=0, o_Done=0, o_Keys_Valid=0.
  - Clears round counter to 0 and rcon to 8'h01.
  - Zeroes all 11 key slots.
  - Reset overrides every other input on the same edge.
  - Reset mid-RUN aborts the schedule; no o_Done is produced.
- States: IDLE, RUN.
- IDLE:
  - i_Start=1 at edge E0 accepts the request.
  - Writes slot0=i_Key and working reg W=i_Key; sets round=1, rcon=01.
  - Sets o_Busy=1 and o_Keys_Valid=0; moves to RUN.
- RUN, edge Er (r=1..10):
  - temp = SubWord(RotWord(W[31:0])) ^ {rcon,24'b0}.
  - w4 = W[127:96]^temp; w5 = W[95:64]^w4; w6 = W[63:32]^w5; w7 = W[31:0]^w6.
  - W and slot r are both set to {w4,w5,w6,w7}.
  - rcon advances by xtime: shift left 1, XOR 8'h1b if bit7 was set. Sequence: 01,02,04,08,10,20,40,80,1b,36.
- At E10:
  - State returns to IDLE; o_Busy=0; o_Keys_Valid=1; o_Done=1 for exactly the following cycle.
- Latency: 10 edges from the accepting edge E0 to o_Done high. The next start can be accepted in the o_Done cycle.
- i_Start while in RUN is ignored: no queuing, and i_Key changes have no effect.
- i_Start held high continuously: a new schedule restarts each time IDLE is reached.
- A new accepted start drops o_Keys_Valid on the accepting edge; all slots are then overwritten in order.
- Read port:
  - o_Rd_Key = slot[i_Rd_Addr], purely combinational.
  - Index >10 returns 128'h0.
  - Reads during RUN are permitted; unwritten slots return their previous contents. Consumers must gate on o_Keys_Valid.
- Only one SubWord path (4 sbox) is instantiated; no other S-box use.

Optional Feature:
KEY_SCHED_ZEROIZE_EN:
- When defined, adds input i_Zeroize (1 bit).
- i_Zeroize=1 at any edge clears all 11 slots and W to 0, forces IDLE, drops o_Busy and o_Keys_Valid, and suppresses o_Done.
- Priority: below i_Reset, above i_Start (start on the same edge is discarded).
- When undefined, the port does not exist and slots are only cleared by i_Reset.

Test Plan:
- FIPS-197 vector: i_Key=2b7e151628aed2a6abf7158809cf4f3c, start pulse -> o_Done exactly 10 edges later. Slot1=a0fafe1788542cb123a339392a6c7605, slot10=d014f9a8c9ee2589e13f0cc8b6630ca6, slot0=input key.
- Rcon coverage: after the vector run, every slot matches the full FIPS-197 expansion (tests 80->1b->36 wrap). Reading i_Rd_Addr=11..15 -> 128'h0.
- Start during RUN: second i_Start with a different key at E4 -> ignored. Same slot values as the first run, one o_Done pulse.
- Reset mid-operation: i_Reset at E5 -> next cycle o_Busy=0, o_Keys_Valid=0, all slots 0, no o_Done. A subsequent start produces the correct schedule.
- Back-to-back: i_Start held high, key changed to 000102030405060708090a0b0c0d0e0f in the o_Done cycle -> restart accepted that edge. Slot10=13111d7fe3944a17f307a78b4d2b30c5.
- KEY_SCHED_ZEROIZE_EN builds only: i_Zeroize together with i_Start at E3 -> IDLE, all slots 0, start discarded, o_Done never pulses.
